// File: rtl/lcd_pkg.sv
// lcd_pkg: opcodes, DDRAM geometry, FSM states and address helpers for the HD44780 responder.
package lcd_pkg;
  localparam logic [7:0] OP_CLEAR       = 8'h01;
  localparam logic [7:0] OP_HOME        = 8'h02;
  localparam logic [7:0] OP_ENTRY_INC   = 8'h06;
  localparam logic [7:0] OP_DISP_ON_CUR = 8'h0E;
  localparam logic [7:0] OP_FUNC_2LINE  = 8'h38;
  localparam logic [7:0] OP_ADDR_LINE1  = 8'h80;
  localparam logic [7:0] OP_ADDR_LINE2  = 8'hC0;
  localparam logic [6:0] LINE1_BASE     = OP_ADDR_LINE1[6:0];
  localparam logic [6:0] LINE2_BASE     = OP_ADDR_LINE2[6:0];
  localparam int         LINE_LEN       = 16;
  typedef enum logic [1:0] {IDLE, EXEC, BUSY} state_t;
  function automatic logic visible(input logic [6:0] a);
    return a[5:0] < 6'(LINE_LEN);
  endfunction
  function automatic logic [4:0] ddram_idx(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction
  // Each line's 40-byte address window wraps into the other line.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    return inc ? (a == 7'h27 ? LINE2_BASE : a == 7'h67 ? LINE1_BASE : a + 7'd1)
               : (a == LINE1_BASE ? 7'h67 : a == LINE2_BASE ? 7'h27 : a - 7'd1);
  endfunction
endpackage

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync: multi-flop synchronizer for EN/RS/RW/DATA with EN edge pulses from the synced copy.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       LCDCLK,
  input  logic       PRESETn,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data,
  output logic       rs_s,
  output logic       rw_s,
  output logic [7:0] data_s,
  output logic       en_rise,
  output logic       en_fall
);
  logic [10:0] pipe [SYNC_STAGES];
  logic        en_s, en_d;
  always_ff @(posedge LCDCLK or negedge PRESETn)
    if (!PRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) pipe[i] <= '0;
      en_d <= 1'b0;
    end else begin
      pipe[0] <= {en, rs, rw, data};
      for (int i = 1; i < SYNC_STAGES; i++) pipe[i] <= pipe[i-1];
      en_d <= en_s;
    end
  assign {en_s, rs_s, rw_s, data_s} = pipe[SYNC_STAGES-1];
  assign en_rise = en_s & ~en_d;
  assign en_fall = ~en_s & en_d;
endmodule

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: display-side HD44780 bus model holding a 2x16 DDRAM image and display state.
// Define LCD_READ_EN to answer RW=1 reads; otherwise read strobes are ignored and the bus is never driven.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES = 80,
  parameter int CLR_CYCLES  = 3040,
  parameter int SYNC_STAGES = 2
) (
  input  logic         LCDCLK,
  input  logic         PRESETn,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic         LCD_EN,
  input  logic [7:0]   LCD_DATA_IN,
  output logic [7:0]   LCD_DATA_OUT,
  output logic         LCD_DATA_OE,
  output logic [255:0] disp_data,
  output logic         disp_on,
  output logic         cursor_on,
  output logic         blink_on,
  output logic         two_line,
  output logic         busy,
  output logic         ovr
);
  localparam int CW = $clog2(CLR_CYCLES + 1);
  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [6:0]    addr;
  logic [7:0]    cmd, data_s;
  logic          inc, cmd_rs, rs_s, rw_s, en_rise, en_fall, wr_fall, drop, is_long;
  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .LCDCLK (LCDCLK),
    .PRESETn(PRESETn),
    .en     (LCD_EN),
    .rs     (LCD_RS),
    .rw     (LCD_RW),
    .data   (LCD_DATA_IN),
    .rs_s   (rs_s),
    .rw_s   (rw_s),
    .data_s (data_s),
    .en_rise(en_rise),
    .en_fall(en_fall)
  );
  assign wr_fall = en_fall & ~rw_s;
  assign is_long = ~cmd_rs & (cmd[7:2] == 6'd0);
  assign busy    = state != IDLE;
  // A 0x00 instruction is accepted as a no-op without entering busy.
  always_comb
    state_nx = state == IDLE ? (wr_fall && (rs_s || data_s != 8'h00) ? EXEC : IDLE)
             : state == EXEC ? BUSY
             : (cnt == '0 ? IDLE : BUSY);
`ifdef LCD_READ_EN
  logic       rd_rs;
  logic [7:0] rd_byte;
  assign drop         = en_fall & busy & (~rw_s | rs_s);
  assign rd_byte      = visible(addr) ? disp_data[{~ddram_idx(addr), 3'b000} +: 8] : 8'h20;
  assign LCD_DATA_OUT = LCD_DATA_OE ? (rd_rs ? rd_byte : {busy, addr}) : 8'h00;
  always_ff @(posedge LCDCLK or negedge PRESETn)
    if (!PRESETn) begin
      LCD_DATA_OE <= 1'b0;
      rd_rs       <= 1'b0;
    end else if (en_rise && rw_s && (!rs_s || !busy)) begin
      LCD_DATA_OE <= 1'b1;
      rd_rs       <= rs_s;
    end else if (en_fall) LCD_DATA_OE <= 1'b0;
`else
  logic unused_rise;
  assign unused_rise  = en_rise;
  assign drop         = wr_fall & busy;
  assign LCD_DATA_OUT = 8'h00;
  assign LCD_DATA_OE  = 1'b0;
`endif
  always_ff @(posedge LCDCLK or negedge PRESETn)
    if (!PRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= LINE1_BASE;
      inc       <= 1'b1;
      cmd       <= 8'h00;
      cmd_rs    <= 1'b0;
      disp_data <= {32{8'h20}};
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      two_line  <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state <= state_nx;
      ovr   <= drop;
      if (state == IDLE && wr_fall) begin
        cmd    <= data_s;
        cmd_rs <= rs_s;
      end
`ifdef LCD_READ_EN
      if (en_fall && rw_s && rs_s && !busy) addr <= addr_step(addr, inc);
`endif
      if (state == EXEC) begin
        cnt <= is_long ? CW'(CLR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
        if (cmd_rs) begin
          if (visible(addr)) disp_data[{~ddram_idx(addr), 3'b000} +: 8] <= cmd;
          addr <= addr_step(addr, inc);
        end else if (cmd[7]) addr <= cmd[6:0];
        else if (cmd[7:5] == OP_FUNC_2LINE[7:5]) two_line <= cmd[3];
        else if (cmd[7:3] == OP_DISP_ON_CUR[7:3]) {disp_on, cursor_on, blink_on} <= cmd[2:0];
        else if (cmd[7:2] == OP_ENTRY_INC[7:2]) inc <= cmd[1];
        else if (cmd[7:1] == OP_HOME[7:1]) addr <= LINE1_BASE;
        else if (cmd == OP_CLEAR) begin
          disp_data <= {32{8'h20}};
          addr      <= LINE1_BASE;
          inc       <= 1'b1;
        end
      end else if (state == BUSY) cnt <= cnt - CW'(1);
    end
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: directed host transactions with a scoreboard checked on each commit and overrun.
module tb_lcd_hd44780_responder;
  localparam int BN = 80, CN = 3040, SN = 2;
  logic         LCDCLK = 0, PRESETn = 0, LCD_RS = 0, LCD_RW = 0, LCD_EN = 0;
  logic [7:0]   LCD_DATA_IN = 0, LCD_DATA_OUT;
  logic         LCD_DATA_OE, disp_on, cursor_on, blink_on, two_line, busy, ovr;
  logic [255:0] disp_data;
  lcd_hd44780_responder #(.BUSY_CYCLES(BN), .CLR_CYCLES(CN), .SYNC_STAGES(SN)) dut (
    .LCDCLK(LCDCLK), .PRESETn(PRESETn), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_DATA_IN(LCD_DATA_IN), .LCD_DATA_OUT(LCD_DATA_OUT), .LCD_DATA_OE(LCD_DATA_OE),
    .disp_data(disp_data), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .busy(busy), .ovr(ovr)
  );
  always #5 LCDCLK = ~LCDCLK;
  typedef struct packed {
    logic         is_ovr;
    logic [3:0]   flags;
    logic [255:0] disp;
  } exp_t;
  exp_t         q[$];
  exp_t         e;
  int           errors = 0, checks = 0;
  logic [255:0] m_disp = {32{8'h20}};
  logic         m_on = 0, m_cur = 0, m_blink = 0, m_two = 0;
  logic         busy_d = 0, pend = 0;
`ifdef LCD_READ_EN
  localparam logic       RD_OE = 1'b1;
  localparam logic [7:0] RD_DATA = 8'h80;
`else
  localparam logic       RD_OE = 1'b0;
  localparam logic [7:0] RD_DATA = 8'h00;
`endif
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic put(input int idx, input logic [7:0] v);
    m_disp[(31 - idx) * 8 +: 8] = v;
  endtask
  task automatic push(input logic o);
    exp_t x;
    x.is_ovr = o;
    x.flags  = {m_on, m_cur, m_blink, m_two};
    x.disp   = m_disp;
    q.push_back(x);
  endtask
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int hi);
    @(posedge LCDCLK); #1;
    LCD_RS = rs; LCD_RW = rw; LCD_DATA_IN = d;
    @(posedge LCDCLK); #1 LCD_EN = 1;
    repeat (hi) @(posedge LCDCLK);
    #1 LCD_EN = 0;
  endtask
  task automatic count_busy(output int n);
    int t = 0;
    n = 0;
    while (!busy && t < 20) begin @(negedge LCDCLK); t++; end
    while (busy && n < 5000) begin n++; @(negedge LCDCLK); end
  endtask
  task automatic send(input logic rs, input logic [7:0] d, input int hi, input int len, input string name);
    int n;
    push(0);
    strobe(rs, 0, d, hi);
    count_busy(n);
    chk(name, n, len);
    repeat (2) @(posedge LCDCLK);
  endtask
  // Commits are compared the cycle after busy rises, once the EXEC update has landed.
  always @(negedge LCDCLK) begin
    if (!PRESETn) begin
      pend   = 0;
      busy_d = 0;
    end else begin
      if (pend) begin
        pend = 0;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got commit required none");
        end else begin
          e = q.pop_front();
          chk("commit_kind", e.is_ovr, 1'b0);
          chk("commit_disp", disp_data, e.disp);
          chk("commit_flags", {disp_on, cursor_on, blink_on, two_line}, e.flags);
        end
      end
      if (ovr) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ovr: got ovr required none");
        end else begin
          e = q.pop_front();
          chk("ovr_kind", e.is_ovr, 1'b1);
          chk("ovr_disp", disp_data, e.disp);
        end
      end
      if (busy && !busy_d) pend = 1;
      busy_d = busy;
    end
  end
  initial begin
    int n;
    #23;
    chk("rst_disp", disp_data, {32{8'h20}});
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_flags", {disp_on, cursor_on, blink_on, two_line}, 4'h0);
    chk("rst_oe", LCD_DATA_OE, 1'b0);
    chk("rst_dout", LCD_DATA_OUT, 8'h00);
    repeat (3) @(posedge LCDCLK);
    #1 PRESETn = 1;
    m_two = 1;
    send(0, 8'h38, 1600, BN + 1, "len_38");
    m_on = 1; m_cur = 1;
    send(0, 8'h0E, 1600, BN + 1, "len_0e");
    send(0, 8'h06, 1600, BN + 1, "len_06");
    send(0, 8'h02, 1600, CN + 1, "len_02");
    send(0, 8'h01, 1600, CN + 1, "len_01");
    send(0, 8'h80, 1600, BN + 1, "len_80");
    chk("init_flags", {disp_on, cursor_on, blink_on, two_line}, 4'b1101);
    chk("init_addr", dut.addr, 7'h00);
    strobe(0, 0, 8'h00, 4);
    count_busy(n);
    chk("noop_busy", n, 0);
    send(0, 8'h18, 4, BN + 1, "len_shift");
    m_cur = 0; m_blink = 1;
    send(0, 8'h0D, 4, BN + 1, "len_0d");
    m_cur = 1; m_blink = 0;
    send(0, 8'h0E, 4, BN + 1, "len_0e_b");
    send(0, 8'h8F, 4, BN + 1, "len_8f");
    put(15, 8'h41);
    send(1, 8'h41, 4, BN + 1, "len_A");
    send(1, 8'h42, 4, BN + 1, "len_B");
    chk("addr_after_B", dut.addr, 7'h11);
    send(0, 8'hC0, 4, BN + 1, "len_c0");
    put(16, 8'h43);
    send(1, 8'h43, 4, BN + 1, "len_C");
    chk("col15_A", disp_data[135:128], 8'h41);
    chk("l2col0_C", disp_data[127:120], 8'h43);
    put(17, 8'h44);
    push(0);
    push(1);
    @(posedge LCDCLK); #1;
    LCD_RS = 1; LCD_RW = 0; LCD_DATA_IN = 8'h44;
    @(posedge LCDCLK); #1 LCD_EN = 1;
    repeat (2) @(posedge LCDCLK);
    #1 LCD_EN = 0;
    @(posedge LCDCLK); #1 LCD_EN = 1; LCD_DATA_IN = 8'h45;
    @(posedge LCDCLK); #1 LCD_EN = 0;
    count_busy(n);
    chk("len_ovr_seq", n, BN + 1);
    chk("l2col1_D", disp_data[119:112], 8'h44);
    chk("l2col2_kept", disp_data[111:104], 8'h20);
    send(0, 8'h04, 4, BN + 1, "len_04");
    send(0, 8'h80, 4, BN + 1, "len_80_b");
    put(0, 8'h30);
    send(1, 8'h30, 4, BN + 1, "len_30");
    chk("col0_30", disp_data[255:248], 8'h30);
    chk("addr_wrap_dec", dut.addr, 7'h67);
    send(1, 8'h31, 4, BN + 1, "len_31");
    chk("addr_67_dec", dut.addr, 7'h66);
    m_disp = {32{8'h20}};
    push(0);
    strobe(0, 0, 8'h01, 4);
    n = 0;
    while (!busy && n < 20) begin @(negedge LCDCLK); n++; end
    chk("clr_busy_seen", busy, 1'b1);
    strobe(0, 1, 8'h00, 5);
    chk("rd_oe_hi", LCD_DATA_OE, RD_OE);
    chk("rd_dout_hi", LCD_DATA_OUT, RD_DATA);
    repeat (4) @(posedge LCDCLK);
    #1;
    chk("rd_oe_lo", LCD_DATA_OE, 1'b0);
    chk("rd_dout_lo", LCD_DATA_OUT, 8'h00);
    count_busy(n);
    chk("clr_tail_done", busy, 1'b0);
    LCD_RW = 0;
    send(0, 8'h80, 4, BN + 1, "len_80_c");
    put(0, 8'h5A);
    push(0);
    strobe(1, 0, 8'h5A, 4);
    repeat (10) @(negedge LCDCLK);
    chk("busy_before_rst", busy, 1'b1);
    #2 PRESETn = 0;
    #1;
    chk("midrst_disp", disp_data, {32{8'h20}});
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_addr", dut.addr, 7'h00);
    chk("midrst_oe", LCD_DATA_OE, 1'b0);
    chk("midrst_flags", {disp_on, cursor_on, blink_on, two_line}, 4'h0);
    chk("queue_drained", q.size(), 0);
    repeat (3) @(posedge LCDCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
